aes_round_sequencer: RTL and testbench

//  FSM/counter block sequencing the 16-bit serial AES-128 state register bank.

---
 rtl/aes_round_sequencer.sv | 130 +++++++++++++
 tb/tb_aes_round_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Control sequencer for a 16-bit serial AES-128 datapath: walks LOAD, SB/SR/MC rounds and
// OUT unload, producing registered strobes that steer the state-register bank and key schedule.
module aes_round_sequencer #(
  parameter int NR       = 10,
  parameter int LD_BEATS = 8,
  parameter int SB_BEATS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       pt_ready,
  output logic       en,
  output logic       doSR,
  output logic       doMC,
  output logic       sel_pt,
  output logic       sel_sb,
  output logic       key_adv,
  output logic [3:0] round,
  output logic       ct_valid,
  output logic       done
);

  localparam int              CW      = $clog2(SB_BEATS);
  localparam logic [CW-1:0]   LD_LAST = CW'(LD_BEATS - 1);
  localparam logic [CW-1:0]   SB_LAST = CW'(SB_BEATS - 1);
  localparam logic [3:0]      NR_L    = 4'(NR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SB,
    S_SR,
    S_MC,
    S_OUT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    round_q, round_d;

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    round_d = round_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (cnt_q == LD_LAST) begin
          state_d = S_SB;
          cnt_d   = '0;
          round_d = 4'd1;
        end
      end
      S_SB: begin
        if (cnt_q == SB_LAST) begin
          state_d = S_SR;
          cnt_d   = '0;
        end
      end
      S_SR: begin
        // The final round skips MixColumns and goes straight to unload.
        cnt_d   = '0;
        state_d = (round_q == NR_L) ? S_OUT : S_MC;
      end
      S_MC: begin
        if (cnt_q == LD_LAST) begin
          state_d = S_SB;
          cnt_d   = '0;
          round_d = round_q + 4'd1;
        end
      end
      S_OUT: begin
        if (cnt_q == LD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          round_d = 4'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        round_d = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with the
  // state they describe and reach the datapath glitch-free.
  // NOTE: sequential state uses non-blocking assignments only; reset clears every flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      round_q  <= 4'd0;
      busy     <= 1'b0;
      pt_ready <= 1'b0;
      en       <= 1'b0;
      doSR     <= 1'b0;
      doMC     <= 1'b0;
      sel_pt   <= 1'b0;
      sel_sb   <= 1'b0;
      key_adv  <= 1'b0;
      ct_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      round_q  <= round_d;
      busy     <= (state_d != S_IDLE);
      pt_ready <= (state_d == S_LOAD);
      sel_pt   <= (state_d == S_LOAD);
      en       <= (state_d == S_SB);
      sel_sb   <= (state_d == S_SB);
      doSR     <= (state_d == S_SR);
      // Even MC beats have a complete column sitting in s0..s3.
      doMC     <= (state_d == S_MC) && !cnt_d[0];
      key_adv  <= (state_d == S_LOAD) || (state_d == S_MC) || (state_d == S_OUT);
      ct_valid <= (state_d == S_OUT);
      done     <= (state_d == S_OUT) && (cnt_d == LD_LAST);
    end
  end

  assign round = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: a timing model pushes the expected output word for
// every cycle of a run into a scoreboard queue, and each cycle pops and compares it.
module tb_aes_round_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy, pt_ready, en, doSR, doMC, sel_pt, sel_sb, key_adv, ct_valid, done;
  logic [3:0] round;

  int checks = 0;
  int errors = 0;

  logic [13:0] exp_q[$];

  aes_round_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .pt_ready (pt_ready),
    .en       (en),
    .doSR     (doSR),
    .doMC     (doMC),
    .sel_pt   (sel_pt),
    .sel_sb   (sel_sb),
    .key_adv  (key_adv),
    .round    (round),
    .ct_valid (ct_valid),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: busy pt_ready en doSR doMC sel_pt sel_sb key_adv round[3:0] ct_valid done
  wire [13:0] obs = {busy, pt_ready, en, doSR, doMC, sel_pt, sel_sb, key_adv, round,
                     ct_valid, done};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Expected outputs k cycles after the cycle in which start was sampled (NR=10 timing).
  function automatic logic [13:0] exp_at(input int k);
    logic b, ptr, e, sr, mc, spt, ssb, kad, ctv, dn;
    logic [3:0] rnd;
    int j, p;
    {b, ptr, e, sr, mc, spt, ssb, kad, ctv, dn} = '0;
    rnd = 4'd0;
    if (k >= 1 && k <= 258) b = 1'b1;
    if (k >= 1 && k <= 8) begin
      ptr = 1'b1; spt = 1'b1; kad = 1'b1;
    end else if (k >= 9 && k <= 250) begin
      j   = k - 9;
      rnd = 4'(j / 25 + 1);
      p   = j % 25;
      if (p < 16) begin
        e = 1'b1; ssb = 1'b1;
      end else if (p == 16) begin
        sr = 1'b1;
      end else begin
        kad = 1'b1;
        mc  = ((p - 17) % 2 == 0);
      end
    end else if (k >= 251 && k <= 258) begin
      rnd = 4'd10; ctv = 1'b1; kad = 1'b1; dn = (k == 258);
    end
    return {b, ptr, e, sr, mc, spt, ssb, kad, rnd, ctv, dn};
  endfunction

  // Called just after start has been driven high at a negedge. hold keeps start high for the
  // whole run; abort_at > 0 fires an asynchronous reset at that cycle instead of finishing.
  task automatic run_block(input string name, input bit hold, input int abort_at);
    int n_en, n_sr, n_mc, n_kad, n_ptr, n_done, overlap;
    logic [13:0] exp_w;
    n_en = 0; n_sr = 0; n_mc = 0; n_kad = 0; n_ptr = 0; n_done = 0; overlap = 0;
    for (int k = 1; k <= 259; k++) exp_q.push_back(exp_at(k));
    for (int k = 1; k <= 259; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        check({name, " async reset clears outputs"}, 32'(obs), 32'h0);
        exp_q.delete();
        return;
      end
      exp_w = exp_q.pop_front();
      check($sformatf("%s cycle T+%0d", name, k), 32'(obs), 32'(exp_w));
      n_en   += int'(en);
      n_sr   += int'(doSR);
      n_mc   += int'(doMC);
      n_kad  += int'(key_adv);
      n_ptr  += int'(pt_ready);
      n_done += int'(done);
      if ((int'(en) + int'(doSR) + int'(doMC)) > 1) overlap++;
    end
    check({name, " en count"},       32'(n_en),    32'd160);
    check({name, " doSR count"},     32'(n_sr),    32'd10);
    check({name, " doMC count"},     32'(n_mc),    32'd36);
    check({name, " key_adv count"},  32'(n_kad),   32'd88);
    check({name, " pt_ready count"}, 32'(n_ptr),   32'd8);
    check({name, " done count"},     32'(n_done),  32'd1);
    check({name, " strobe overlap"}, 32'(overlap), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    #1;
    check("reset asserted, outputs", 32'(obs), 32'h0);
    // start while in reset must not launch anything
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("reset held across edges", 32'(obs), 32'h0);
    start = 1'b0;
    rst   = 1'b0;
    repeat (3) @(negedge clk);
    check("idle after reset release", 32'(obs), 32'h0);

    // Single run with a one-cycle start pulse, then confirm it stays idle.
    start = 1'b1;
    run_block("single", 1'b0, 0);
    repeat (4) @(negedge clk);
    check("idle without start", 32'(obs), 32'h0);

    // start held through a whole run: exactly one run, then a second one from T+259.
    start = 1'b1;
    run_block("held_first", 1'b1, 0);
    run_block("held_second", 1'b0, 0);

    // Reset mid-operation, then a clean full run.
    repeat (2) @(negedge clk);
    start = 1'b1;
    run_block("abort", 1'b0, 100);
    @(negedge clk);
    check("reset held mid-run", 32'(obs), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle after mid-run reset", 32'(obs), 32'h0);
    start = 1'b1;
    run_block("after_reset", 1'b0, 0);

    // Back-to-back: start presented in the idle cycle right after done.
    start = 1'b1;
    run_block("b2b_second", 1'b0, 0);
    @(negedge clk);
    check("final idle", 32'(obs), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
